// File: rtl/regfile_scoreboard_if.sv
// Register-file / scoreboard bus: read ports, writeback port, issue port and flush.
// The core drives the master side; the register file sits on the slave side.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   ra1;
  logic [AW-1:0]   ra2;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            pend1;
  logic            pend2;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            iss_busy;
  logic            flush;
  logic [AW:0]     pend_cnt;

  modport master (
    output ra1, ra2, we, wa, wd, iss_valid, iss_rd, flush,
    input  rd1, rd2, pend1, pend2, iss_busy, pend_cnt
  );

  modport slave (
    input  ra1, ra2, we, wa, wd, iss_valid, iss_rd, flush,
    output rd1, rd2, pend1, pend2, iss_busy, pend_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits for in-order issue.
// Register 0 is hardwired to zero and can never become pending.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               rst,
  regfile_scoreboard_if.slave bus
);
  localparam int unsigned NREGS = 2 ** AW;
  localparam int          CW    = AW + 1;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [CW-1:0]    cnt;

  logic wr_hit;
  logic iss_acc;
  logic inc;
  logic dec;
  logic byp1;
  logic byp2;

  always_comb begin
    wr_hit       = bus.we && (bus.wa != '0);
    bus.iss_busy = bus.iss_valid && (bus.iss_rd != '0) && pending[bus.iss_rd]
                   && !(bus.we && (bus.wa == bus.iss_rd));
    iss_acc      = bus.iss_valid && !bus.iss_busy && (bus.iss_rd != '0) && !bus.flush;
    // Counter follows the popcount: a writeback to the register being issued does not clear it.
    inc          = iss_acc && !pending[bus.iss_rd];
    dec          = wr_hit && pending[bus.wa] && !(iss_acc && (bus.iss_rd == bus.wa));
  end

  always_comb begin
    byp1     = (BYPASS != 0) && wr_hit && (bus.wa == bus.ra1);
    byp2     = (BYPASS != 0) && wr_hit && (bus.wa == bus.ra2);
    bus.rd1  = byp1 ? bus.wd : ((bus.ra1 == '0) ? '0 : regs[bus.ra1]);
    bus.rd2  = byp2 ? bus.wd : ((bus.ra2 == '0) ? '0 : regs[bus.ra2]);
    bus.pend1 = pending[bus.ra1] && !byp1;
    bus.pend2 = pending[bus.ra2] && !byp2;
  end

  assign bus.pend_cnt = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs    <= '{default: '0};
      pending <= '0;
      cnt     <= '0;
    end else begin
      if (wr_hit) begin
        regs[bus.wa]    <= bus.wd;
        pending[bus.wa] <= 1'b0;
      end
      // Later assignments take priority: issue beats writeback, flush beats both.
      if (iss_acc)
        pending[bus.iss_rd] <= 1'b1;
      if (bus.flush)
        pending <= '0;
      cnt <= bus.flush ? '0 : (cnt + CW'(inc) - CW'(dec));
    end
  end
endmodule
